// File: rtl/jk_bank_pkg.sv
// Shared types and the per-cell JK update rule for the JK bank arbiter.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_SET  = 2'b01,
        JK_CLR  = 2'b10,
        JK_TGL  = 2'b11
    } jk_op_t;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    function automatic logic jk_next(jk_op_t op, logic q);
        case (op)
            JK_HOLD: return q;
            JK_SET:  return 1'b1;
            JK_CLR:  return 1'b0;
            JK_TGL:  return ~q;
            default: return q;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Request bus of the JK bank arbiter: per-requester command fields plus one-hot ready.
interface jk_bank_arbiter_if #(
    parameter int unsigned W    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [W*NREQ-1:0]    req_mask;
    logic [CNTW*NREQ-1:0] req_rpt;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid, req_op, req_mask, req_rpt, req_lock,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_op, req_mask, req_rpt, req_lock,
        output req_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int unsigned IDW = $clog2(NREQ);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (32'(ptr) + 32'(k)) % NREQ;
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin shared JK cell bank; one command per grant, applied rpt+1 times.
// Optional keep-grant lock feature compiled in with macro JK_LOCK_EN.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    jk_bank_arbiter_if.slave        bus,
    output logic [W-1:0]            q,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id
);
    localparam int unsigned IDW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
    jk_op_t          op_q, op_d;
    logic [W-1:0]    mask_q, mask_d, bank_q, bank_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0] arb_valid, grant;
    logic [IDW-1:0]  win;
    logic            any;
    logic            adv;

`ifdef JK_LOCK_EN
    logic           lock_vld_q, lock_vld_d, cmd_lock_q, cmd_lock_d;
    logic [IDW-1:0] lock_owner_q, lock_owner_d;

    assign arb_valid = lock_vld_q ? (bus.req_valid & (NREQ'(1) << lock_owner_q)) : bus.req_valid;
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign arb_valid   = bus.req_valid;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .valid (arb_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        op_d          = op_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        bank_d        = bank_q;
        adv           = 1'b1;
        bus.req_ready = '0;
`ifdef JK_LOCK_EN
        lock_vld_d    = lock_vld_q;
        lock_owner_d  = lock_owner_q;
        cmd_lock_d    = cmd_lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    bus.req_ready = grant;
                    id_d          = win;
                    op_d          = jk_op_t'(bus.req_op[2*win +: 2]);
                    mask_d        = bus.req_mask[W*win +: W];
                    cnt_d         = bus.req_rpt[CNTW*win +: CNTW];
                    state_d       = APPLY;
`ifdef JK_LOCK_EN
                    cmd_lock_d = bus.req_lock[win];
                    if (bus.req_lock[win]) begin
                        lock_vld_d   = 1'b1;
                        lock_owner_d = win;
                    end
`endif
                end
            end
            APPLY: begin
                for (int b = 0; b < W; b++) begin
                    bank_d[b] = mask_q[b] ? jk_next(op_q, bank_q[b]) : bank_q[b];
                end
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE: begin
                state_d = IDLE;
`ifdef JK_LOCK_EN
                // Owner's unlocked command releases the lock; otherwise ptr is frozen.
                if (lock_vld_q) begin
                    if (id_q == lock_owner_q && !cmd_lock_q) lock_vld_d = 1'b0;
                    else                                     adv        = 1'b0;
                end
`endif
                if (adv) ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= JK_HOLD;
            mask_q  <= '0;
            cnt_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

`ifdef JK_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld_q   <= 1'b0;
            lock_owner_q <= '0;
            cmd_lock_q   <= 1'b0;
        end else begin
            lock_vld_q   <= lock_vld_d;
            lock_owner_q <= lock_owner_d;
            cmd_lock_q   <= cmd_lock_d;
        end
    end
`endif

    assign q       = bank_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done ? id_q : '0;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (W=8, NREQ=4, CNTW=4); honours JK_LOCK_EN.
module tb_jk_bank_arbiter;
    import jk_bank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] q;
    logic       busy, done;
    logic [1:0] done_id;
    int         total = 0;
    int         bad = 0;
    int         done_at, ndone, nbusy, last_id;

    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.W(8), .NREQ(4), .CNTW(4)) bus ();

    jk_bank_arbiter #(.W(8), .NREQ(4), .CNTW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input jk_op_t op, input logic [7:0] m,
                           input logic [3:0] r, input logic v, input logic lk);
        bus.req_valid[i]       = v;
        bus.req_op[2*i +: 2]   = op;
        bus.req_mask[8*i +: 8] = m;
        bus.req_rpt[4*i +: 4]  = r;
        bus.req_lock[i]        = lk;
    endtask

    // Watch n cycles after a handshake; valid is dropped in the first one.
    task automatic watch(input int n);
        done_at = 0; ndone = 0; nbusy = 0; last_id = -1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = '0;
            #1;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_at = k;
                last_id = int'(done_id);
            end
        end
    endtask

    task automatic grant_expect(input int id, input string tag);
        int n;
        logic [3:0] e;
        e = 4'b0001 << id;
        n = 0;
        #1;
        while (bus.req_ready == 4'b0 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_grant"}, 32'(bus.req_ready), 32'(e));
        n = 0;
        @(negedge clk); #1;
        while (!done && n < 40) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_done_id"}, 32'(done_id), 32'(id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_mask  = '0;
        bus.req_rpt   = '0;
        bus.req_lock  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_done_id", 32'(done_id), 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // req0 SET 0F rpt 0: q final end of t+1, done only in t+2
        @(negedge clk);
        set_req(0, JK_SET, 8'h0F, 4'd0, 1'b1, 1'b0);
        #1 chk("t2_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("t2_busy_t1", 32'(busy), 32'h1);
        chk("t2_q_t1", 32'(q), 32'h00);
        chk("t2_done_t1", 32'(done), 32'h0);
        @(negedge clk); #1;
        chk("t2_q_t2", 32'(q), 32'h0F);
        chk("t2_done_t2", 32'(done), 32'h1);
        chk("t2_done_id", 32'(done_id), 32'h0);
        @(negedge clk); #1;
        chk("t2_done_t3", 32'(done), 32'h0);
        chk("t2_busy_t3", 32'(busy), 32'h0);

        // req1 TGL FF rpt 2: three toggles, busy 4 cycles
        set_req(1, JK_TGL, 8'hFF, 4'd2, 1'b1, 1'b0);
        #1 chk("t3_ready", 32'(bus.req_ready), 32'h2);
        watch(6);
        chk("t3_busy_cycles", 32'(nbusy), 32'd4);
        chk("t3_done_at", 32'(done_at), 32'd4);
        chk("t3_ndone", 32'(ndone), 32'd1);
        chk("t3_done_id", 32'(last_id), 32'd1);
        chk("t3_q", 32'(q), 32'hF0);

        // req2 CLR mask 00 rpt 5: q unchanged, done 7 cycles after handshake
        set_req(2, JK_CLR, 8'h00, 4'd5, 1'b1, 1'b0);
        #1 chk("t5_ready", 32'(bus.req_ready), 32'h4);
        watch(9);
        chk("t5_done_at", 32'(done_at), 32'd7);
        chk("t5_ndone", 32'(ndone), 32'd1);
        chk("t5_busy_cycles", 32'(nbusy), 32'd7);
        chk("t5_done_id", 32'(last_id), 32'd2);
        chk("t5_q", 32'(q), 32'hF0);

        // ptr=3 now: req2 TGL rpt 5 wins by wrap, then reset mid-APPLY
        set_req(2, JK_TGL, 8'hFF, 4'd5, 1'b1, 1'b0);
        #1 chk("t1_ready", 32'(bus.req_ready), 32'h4);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); #1;
        chk("t1_q_one_apply", 32'(q), 32'h0F);
        chk("t1_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t1_q_rst", 32'(q), 32'h00);
        chk("t1_busy_rst", 32'(busy), 32'h0);
        chk("t1_done_rst", 32'(done), 32'h0);
        watch(3);
        chk("t1_no_done", 32'(ndone), 32'd0);
        chk("t1_no_busy", 32'(nbusy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // all four valid after reset: 0,1,2,3 then 0,1; then {0,3} -> 3 before 0
        for (int i = 0; i < 4; i++) set_req(i, JK_HOLD, 8'h00, 4'd0, 1'b1, 1'b0);
        grant_expect(0, "t4_a0");
        grant_expect(1, "t4_a1");
        grant_expect(2, "t4_a2");
        grant_expect(3, "t4_a3");
        grant_expect(0, "t4_b0");
        grant_expect(1, "t4_b1");
        bus.req_valid = 4'b1001;
        grant_expect(3, "t4_c3");
        grant_expect(0, "t4_c0");

        // req0 and req2 always valid; req2 requests the lock at first
        bus.req_valid   = 4'b0101;
        bus.req_lock[2] = 1'b1;
        grant_expect(2, "t6_g1");
`ifdef JK_LOCK_EN
        grant_expect(2, "t6_g2");
`else
        grant_expect(0, "t6_g2");
`endif
        bus.req_lock[2] = 1'b0;
        grant_expect(2, "t6_g3");
        grant_expect(0, "t6_g4");
        bus.req_valid = '0;

        // rpt at maximum: 16 toggles of bit 0 leave it unchanged
        @(negedge clk);
        set_req(1, JK_TGL, 8'h01, 4'hF, 1'b1, 1'b0);
        #1 chk("tmax_ready", 32'(bus.req_ready), 32'h2);
        watch(19);
        chk("tmax_done_at", 32'(done_at), 32'd17);
        chk("tmax_ndone", 32'(ndone), 32'd1);
        chk("tmax_busy_cycles", 32'(nbusy), 32'd17);
        chk("tmax_q", 32'(q), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
